// File: rtl/tx_engine_raw.sv
// Raw MAC transmit engine: pops a frame descriptor and its packed data words,
// then emits preamble, SFD, payload, zero padding, FCS and inter-frame gap on
// the internal byte-wide GMII-style interface.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | wait for a descriptor; pop it and latch the length
// LOAD     | classify length: empty, oversize (drop) or transmit
// PREAMBLE | 7 bytes of 0x55
// SFD      | one byte 0xD5
// DATA     | payload bytes, one per cycle, lanes 0..3 of each data word
// PAD      | zero bytes until MIN_LEN bytes have been sent
// FCS      | 4 bytes of crc_value, LSB byte first
// DRAIN    | tx silent; pop the frame's remaining data words
// GAP      | tx silent; enforce the inter-frame gap
module tx_engine_raw #(
  parameter int IFG     = 12,
  parameter int MIN_LEN = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        jumboframes,
  output logic [31:0] tx_count,
  output logic [15:0] tx_drop_count,
  input  logic [13:0] tfq_dout,
  input  logic        tfq_empty,
  output logic        tfq_re,
  input  logic [35:0] txff_dout,
  input  logic        txff_empty,
  output logic        txff_re,
  output logic        crc_init,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  input  logic [31:0] crc_value,
  output logic [7:0]  int_tx_dout,
  output logic        int_tx_en,
  output logic        int_tx_er
);

  typedef enum logic [3:0] {
    IDLE, LOAD, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, GAP
  } state_t;

  localparam logic [13:0] MAX_STD   = 14'd1514;
  localparam logic [13:0] MAX_JUMBO = 14'd9014;
  localparam logic [13:0] MIN_LEN_W = 14'(MIN_LEN);
  // IDLE and LOAD each add one silent cycle before the next preamble, so the
  // GAP state itself lasts IFG-2 cycles to make back-to-back spacing exactly IFG.
  localparam logic [7:0]  GAP_LOAD  = 8'((IFG > 2) ? IFG - 3 : 0);
  localparam logic [7:0]  PRE_LOAD  = 8'd6;
  localparam logic [7:0]  FCS_LOAD  = 8'd3;

  state_t      state, state_nxt;
  logic [13:0] len, len_nxt;
  logic [13:0] byte_cnt, byte_cnt_nxt;
  logic [1:0]  lane, lane_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [12:0] words_left, words_left_nxt;
  logic [7:0]  dout_nxt;
  logic        en_nxt, er_nxt;
  logic        inc_tx, inc_drop;
  logic        tfq_re_c;

  logic [13:0] max_len;
  logic [14:0] len_round;
  logic [13:0] byte_cnt_inc;
  logic [1:0]  fcs_idx;
  logic [7:0]  lane_byte;
  logic [7:0]  fcs_byte;
  logic        unused_sep_bits;

  assign max_len      = jumboframes ? MAX_JUMBO : MAX_STD;
  assign len_round    = {1'b0, len} + 15'd3;
  assign byte_cnt_inc = byte_cnt + 14'd1;
  assign fcs_idx      = 2'd3 - timer[1:0];
  // Separator bits of each 9-bit lane carry no payload.
  assign unused_sep_bits = ^{txff_dout[35], txff_dout[26], txff_dout[17], txff_dout[8]};

  // A pop while reset holds the FSM in IDLE would never be latched, so block it.
  assign tfq_re = tfq_re_c & reset_n;

  // Select the current payload byte from the head data word.
  always_comb begin
    lane_byte = txff_dout[34:27];
    case (lane)
      2'd0: lane_byte = txff_dout[34:27];
      2'd1: lane_byte = txff_dout[25:18];
      2'd2: lane_byte = txff_dout[16:9];
      2'd3: lane_byte = txff_dout[7:0];
      default: lane_byte = txff_dout[34:27];
    endcase
  end

  // Select the FCS byte, least significant byte first.
  always_comb begin
    fcs_byte = crc_value[7:0];
    case (fcs_idx)
      2'd0: fcs_byte = crc_value[7:0];
      2'd1: fcs_byte = crc_value[15:8];
      2'd2: fcs_byte = crc_value[23:16];
      2'd3: fcs_byte = crc_value[31:24];
      default: fcs_byte = crc_value[7:0];
    endcase
  end

  // Next-state, FIFO/CRC strobes and the byte to register onto the tx interface.
  always_comb begin
    state_nxt      = state;
    len_nxt        = len;
    byte_cnt_nxt   = byte_cnt;
    lane_nxt       = lane;
    timer_nxt      = timer;
    words_left_nxt = words_left;
    tfq_re_c       = 1'b0;
    txff_re        = 1'b0;
    crc_init       = 1'b0;
    crc_en         = 1'b0;
    crc_data       = 8'h00;
    dout_nxt       = 8'h00;
    en_nxt         = 1'b0;
    er_nxt         = 1'b0;
    inc_tx         = 1'b0;
    inc_drop       = 1'b0;

    case (state)
      IDLE: begin
        if (!tfq_empty) begin
          tfq_re_c  = 1'b1;
          len_nxt   = tfq_dout;
          state_nxt = LOAD;
        end
      end

      LOAD: begin
        byte_cnt_nxt   = 14'd0;
        lane_nxt       = 2'd0;
        words_left_nxt = len_round[14:2];
        if (len == 14'd0) begin
          timer_nxt = GAP_LOAD;
          state_nxt = GAP;
        end else if (len > max_len) begin
          inc_drop  = 1'b1;
          state_nxt = DRAIN;
        end else begin
          crc_init  = 1'b1;
          timer_nxt = PRE_LOAD;
          state_nxt = PREAMBLE;
        end
      end

      PREAMBLE: begin
        en_nxt   = 1'b1;
        dout_nxt = 8'h55;
        if (timer == 8'd0) state_nxt = SFD;
        else               timer_nxt = timer - 8'd1;
      end

      SFD: begin
        en_nxt    = 1'b1;
        dout_nxt  = 8'hD5;
        state_nxt = DATA;
      end

      DATA: begin
        if (txff_empty) begin
          // Underrun: poison the frame on the wire and discard the rest.
          en_nxt    = 1'b1;
          er_nxt    = 1'b1;
          inc_drop  = 1'b1;
          state_nxt = DRAIN;
        end else begin
          en_nxt       = 1'b1;
          dout_nxt     = lane_byte;
          crc_en       = 1'b1;
          crc_data     = lane_byte;
          byte_cnt_nxt = byte_cnt_inc;
          lane_nxt     = lane + 2'd1;
          if (byte_cnt_inc == len) begin
            txff_re        = 1'b1;
            words_left_nxt = words_left - 13'd1;
            lane_nxt       = 2'd0;
            if (len < MIN_LEN_W) begin
              state_nxt = PAD;
            end else begin
              timer_nxt = FCS_LOAD;
              state_nxt = FCS;
            end
          end else if (lane == 2'd3) begin
            txff_re        = 1'b1;
            words_left_nxt = words_left - 13'd1;
          end
        end
      end

      PAD: begin
        en_nxt       = 1'b1;
        crc_en       = 1'b1;
        byte_cnt_nxt = byte_cnt_inc;
        if (byte_cnt_inc == MIN_LEN_W) begin
          timer_nxt = FCS_LOAD;
          state_nxt = FCS;
        end
      end

      FCS: begin
        en_nxt   = 1'b1;
        dout_nxt = fcs_byte;
        if (timer == 8'd0) begin
          inc_tx    = 1'b1;
          timer_nxt = GAP_LOAD;
          state_nxt = GAP;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end

      DRAIN: begin
        if (words_left == 13'd0) begin
          timer_nxt = GAP_LOAD;
          state_nxt = GAP;
        end else if (!txff_empty) begin
          txff_re        = 1'b1;
          words_left_nxt = words_left - 13'd1;
        end
      end

      GAP: begin
        if (timer == 8'd0) state_nxt = IDLE;
        else               timer_nxt = timer - 8'd1;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, frame bookkeeping and registered tx interface.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      len         <= 14'd0;
      byte_cnt    <= 14'd0;
      lane        <= 2'd0;
      timer       <= 8'd0;
      words_left  <= 13'd0;
      int_tx_dout <= 8'h00;
      int_tx_en   <= 1'b0;
      int_tx_er   <= 1'b0;
    end else begin
      state       <= state_nxt;
      len         <= len_nxt;
      byte_cnt    <= byte_cnt_nxt;
      lane        <= lane_nxt;
      timer       <= timer_nxt;
      words_left  <= words_left_nxt;
      int_tx_dout <= dout_nxt;
      int_tx_en   <= en_nxt;
      int_tx_er   <= er_nxt;
    end
  end

  // Frame statistics; both wrap silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_count      <= 32'd0;
      tx_drop_count <= 16'd0;
    end else begin
      if (inc_tx)   tx_count      <= tx_count + 32'd1;
      if (inc_drop) tx_drop_count <= tx_drop_count + 16'd1;
    end
  end

endmodule

// File: doc/tx_engine_raw.md
Name: tx_engine_raw

Overview:
- Transmit-side counterpart of the raw MAC receive engine.
- Pops frame descriptors (byte length) from a tx frame queue and the matching packed data words from the tx data FIFO.
- Emits preamble, SFD, payload, zero padding to minimum size, FCS and inter-frame gap on the internal byte-wide GMII-style interface.
- Sits between the host-side tx FIFOs and the PHY interface block; FCS comes from the shared external CRC-32 unit.

Parameters:
- IFG, 12, idle cycles (tx_en low) enforced after each FCS or abort.
- MIN_LEN, 60, minimum frame bytes before FCS; shorter frames are zero-padded.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- jumboframes  in  1  1: max length 9014, 0: max length 1514 (bytes, FCS excluded)
- tx_count  out  32  frames fully transmitted
- tx_drop_count  out  16  frames dropped (oversize or underrun)
- tfq_dout  in  14  frame byte length, FCS excluded
- tfq_empty  in  1  frame queue empty
- tfq_re  out  1  frame queue pop
- txff_dout  in  36  data word, first-word-fall-through; bytes in order [34:27],[25:18],[16:9],[7:0]; bits 35/26/17/8 ignored
- txff_empty  in  1  data FIFO empty
- txff_re  out  1  data FIFO pop
- crc_init  out  1  reset CRC accumulator
- crc_en  out  1  accumulate crc_data this cycle
- crc_data  out  8  byte into CRC
- crc_value  in  32  final FCS, complemented; transmitted [7:0],[15:8],[23:16],[31:24]; valid the cycle after the last crc_en
- int_tx_dout  out  8  tx byte
- int_tx_en  out  1  tx enable
- int_tx_er  out  1  tx error

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters 0.
  - Asserting reset mid-frame drops tx_en immediately and abandons the frame; FIFO contents are not drained.
- All int_tx_* outputs are registered. The byte decided in cycle N appears in cycle N+1.
- States: IDLE, LOAD, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, GAP.
- IDLE: on ~tfq_empty, pulse tfq_re and latch len=tfq_dout, then go to LOAD.
- LOAD:
  - len==0: go to GAP; nothing sent, nothing counted.
  - len greater than max (1514/9014): go to DRAIN with flag drop.
  - Otherwise: pulse crc_init, go to PREAMBLE.
- PREAMBLE: 7 bytes 0x55, then SFD emits 0xD5. Neither feeds the CRC.
- DATA:
  - One byte per cycle; byte lane advances 0..3 with crc_en=1.
  - txff_re pulses on the cycle lane 3 is consumed, or on the last byte of the frame whatever its lane. Remaining lanes of the last word are discarded.
  - Byte counter is 14 bits and counts to len.
- Underrun: txff_empty when a new word is needed in DATA means:
  - Emit one byte with int_tx_en=1, int_tx_er=1, data 0x00.
  - Go to DRAIN.
  - Increment tx_drop_count; no FCS.
- After the last data byte:
  - len<MIN_LEN: go to PAD and emit 0x00 with crc_en until MIN_LEN bytes total.
  - Otherwise: go to FCS.
- FCS: 4 bytes of crc_value, LSB byte first, crc_en=0. Then increment tx_count, go to GAP.
- DRAIN:
  - int_tx_en=0.
  - Pop the remaining ceil(len/4) words of the frame as they become available (waits on txff_empty).
  - Drop flag increments tx_drop_count once on entry.
  - Then go to GAP.
- GAP: IFG cycles with int_tx_en=0, then go to IDLE. Back-to-back frames therefore have exactly IFG idle cycles.
- tfq_re and txff_re are never asserted while the respective empty flag is high.
- Counters wrap silently.

Test Plan:
- 64-byte frame (16 words, bytes 0x00..0x3F):
  - Required: 7×0x55, 0xD5, bytes 0x00..0x3F, 4 FCS bytes; int_tx_en high 76 cycles.
  - Required: 16 txff_re pulses; tx_count=1.
- 17-byte frame:
  - Required: 17 data bytes then 43 bytes 0x00, FCS over 60 bytes; 5 words popped (last word lanes 1..3 discarded).
- Two queued 100-byte frames:
  - Required: exactly 12 cycles of int_tx_en=0 between the FCS of the first and the preamble of the second; tx_count=2.
- Length 1600, jumboframes=0:
  - Required: no int_tx_en; 400 words popped; tx_drop_count=1.
- Same frame with jumboframes=1:
  - Required: transmitted; tx_count increments.
- Underrun (txff_empty asserted after word 3 of a 64-byte frame):
  - Required: one byte with int_tx_er=1, then tx_en low.
  - Required: remaining 13 words drained when supplied; tx_drop_count=1; tx_count unchanged.
- reset_n low during DATA:
  - Required: int_tx_en=0 the same cycle, all counters 0.
  - Required: a subsequent frame transmits normally.
